// File: rtl/mem_line_pkg.sv
// Shared types and helpers for the cache-line burst sequencer.
// The FSM state encoding and the line-base mask live here so that the top level and its counter use the same definitions.
package mem_line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } line_state_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = 32;

  // Clears the in-line offset bits. Callers truncate the result to their own address width.
  function automatic logic [63:0] line_base_mask(input int words);
    return ~(64'(words * WORD_BYTES) - 64'd1);
  endfunction

endpackage

// File: rtl/line_beat_ctr.sv
// Beat counter for one line burst.
// Holds the beat count k and the start word s, and derives from them the wrapped word index and the beat byte address.
module line_beat_ctr
  import mem_line_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic [$clog2(WORDS)-1:0]   i_start,
  input  logic                       i_en,
  input  logic [AW-1:0]              i_base,
  output logic [$clog2(WORDS)-1:0]   o_word,
  output logic [AW-1:0]              o_addr,
  output logic                       o_last_beat
);

  localparam int LW = $clog2(WORDS);
  localparam int OB = $clog2(WORD_BYTES);

  logic [LW-1:0] r_k;
  logic [LW-1:0] r_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
      r_s <= '0;
    end else if (i_load) begin
      r_k <= '0;
      r_s <= i_start;
    end else if (i_en) begin
      r_k <= r_k + 1'b1;
    end
  end

  // The LW-bit add wraps inside the line. The base has its offset bits cleared, so OR-ing in the offset can never carry into the line address.
  assign o_word      = r_s + r_k;
  assign o_addr      = i_base | AW'({o_word, OB'(0)});
  assign o_last_beat = (r_k == LW'(WORDS - 1));

endmodule

// File: rtl/mem_line_ctrl.sv
// Cache-line burst sequencer: one line fill or writeback becomes WORDS single-word memory beats.
// Fills are issued critical-word-first and wrap within the line; the line is returned on a valid/ready response.
module mem_line_ctrl
  import mem_line_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AW-1:0]         req_addr,
  input  logic [WORDS*32-1:0]   req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORDS*32-1:0]   resp_rdata,
  output logic                  HSEL,
  output logic                  re,
  output logic                  we,
  output logic [AW-1:0]         a,
  output logic [31:0]           wd,
  input  logic [31:0]           rd,
  input  logic                  Valid
);

  localparam int LW = $clog2(WORDS);
  localparam int OB = $clog2(WORD_BYTES);

  line_state_t                         r_state;
  line_state_t                         w_next;
  logic [AW-1:0]                       r_base;
  logic [WORDS-1:0][WORD_BITS-1:0]     r_buf;

  logic                                w_accept;
  logic                                w_busy;
  logic                                w_beat_done;
  logic [AW-1:0]                       w_mask;
  logic [LW-1:0]                       w_start;
  logic [LW-1:0]                       w_word;
  logic [AW-1:0]                       w_beat_addr;
  logic                                w_last;

  assign w_mask      = AW'(line_base_mask(WORDS));
  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_busy      = (r_state == READ) || (r_state == WRITE);
  assign w_beat_done = w_busy && Valid;
  // Writebacks always start at word 0; only fills go critical-word-first.
  assign w_start     = req_write ? '0 : req_addr[LW+OB-1:OB];

  line_beat_ctr #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ctr (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_start     (w_start),
    .i_en        (w_beat_done),
    .i_base      (r_base),
    .o_word      (w_word),
    .o_addr      (w_beat_addr),
    .o_last_beat (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Memory-side outputs decode from registered state only, so req_* has no combinational path to them.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    HSEL       = 1'b0;
    re         = 1'b0;
    we         = 1'b0;
    a          = '0;
    wd         = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = req_write ? WRITE : READ;
      end
      READ: begin
        HSEL = 1'b1;
        re   = 1'b1;
        a    = w_beat_addr;
        if (Valid && w_last) w_next = RESP;
      end
      WRITE: begin
        HSEL = 1'b1;
        we   = 1'b1;
        a    = w_beat_addr;
        wd   = r_buf[w_word];
        if (Valid && w_last) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
      r_buf  <= '0;
    end else if (w_accept) begin
      r_base <= req_addr & w_mask;
      if (req_write) r_buf <= req_wdata;
    end else if ((r_state == READ) && Valid) begin
      r_buf[w_word] <= rd;
    end
  end

  assign resp_rdata = r_buf;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: stimulus pushes expected beats and responses, and a negedge monitor checks them.
// The reference is a word-addressed memory model plus line/wrap arithmetic.
module tb_mem_line_ctrl;

  localparam int WORDS = 4;
  localparam int AW    = 32;
  localparam int LB    = WORDS * 32;

  logic          clk, reset;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr;
  logic [LB-1:0] req_wdata, resp_rdata;
  logic          resp_valid, resp_ready;
  logic          HSEL, re, we, Valid;
  logic [31:0]   a, wd, rd;

  mem_line_ctrl #(.WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .HSEL(HSEL), .re(re), .we(we), .a(a), .wd(wd), .rd(rd), .Valid(Valid)
  );

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } beat_t;
  typedef struct { logic [LB-1:0] line; int lat; } resp_t;

  beat_t bq[$];
  resp_t rq[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, accept_cyc = 0;
  int vmode = 0, rmode = 0;
  bit rfirst = 0;
  bit pend_v = 0;
  logic [31:0] pend_a, pend_d;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] memrd(input logic [31:0] ad);
    if (mem.exists(ad)) return mem[ad];
    return ad ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] ad);
    if (ref_mem.exists(ad)) return ref_mem[ad];
    return ad ^ 32'h5A5A5A5A;
  endfunction

  // Memory side: Valid/rd/resp_ready change just after the active edge; writes commit on the edge ending a beat.
  always @(posedge clk) begin
    if (pend_v && !reset) mem[pend_a] = pend_d;
    #1;
    case (vmode)
      0: Valid = 1'b1;
      1: Valid = ($urandom_range(0, 3) != 0);
      default: Valid = !(((cyc - accept_cyc) == 2) || ((cyc - accept_cyc) == 3));
    endcase
    case (rmode)
      0: resp_ready = 1'b1;
      1: resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
    rd = memrd(a);
  end

  // Monitor: compares the bus and the response against the scoreboard queues.
  always @(negedge clk) begin
    beat_t b;
    pend_v = !reset && we && Valid;
    pend_a = a;
    pend_d = wd;
    if (!reset) begin
      chk("req_ready", LB'(req_ready), LB'(!HSEL && !resp_valid));
      if (HSEL) begin
        if (bq.size() == 0) chk("spurious_beat", LB'(HSEL), LB'(0));
        else begin
          b = bq[0];
          chk("beat_re", LB'(re), LB'(!b.w));
          chk("beat_we", LB'(we), LB'(b.w));
          chk("beat_a", LB'(a), LB'(b.a));
          if (b.w) chk("beat_wd", LB'(wd), LB'(b.d));
          if (Valid) void'(bq.pop_front());
        end
      end else begin
        chk("idle_a", LB'(a), LB'(0));
        chk("idle_wd", LB'(wd), LB'(0));
        chk("idle_rewe", LB'({re, we}), LB'(0));
      end
      if (resp_valid) begin
        if (rq.size() == 0) chk("spurious_resp", LB'(resp_valid), LB'(0));
        else begin
          chk("resp_rdata", resp_rdata, rq[0].line);
          if (!rfirst) begin
            rfirst = 1;
            if (rq[0].lat >= 0) chk("resp_latency", LB'(cyc - accept_cyc), LB'(rq[0].lat));
          end
          if (resp_ready) begin
            void'(rq.pop_front());
            rfirst = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] ad, input logic [LB-1:0] wdat, input int lat);
    beat_t b;
    resp_t r;
    logic [31:0] base;
    int s, w, guard;
    @(negedge clk);
    req_write = wr; req_addr = ad; req_wdata = wdat; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 500) begin @(negedge clk); guard++; end
    if (guard >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: req_ready never rose for addr %h", ad);
      req_valid = 1'b0;
      return;
    end
    base = ad & ~32'(WORDS * 4 - 1);
    s = wr ? 0 : int'((ad / 4) % 32'(WORDS));
    r.lat = lat;
    for (int i = 0; i < WORDS; i++) begin
      if (wr) begin
        r.line[32*i +: 32] = wdat[32*i +: 32];
        ref_mem[base + 32'(4*i)] = wdat[32*i +: 32];
      end else begin
        r.line[32*i +: 32] = ref_rd(base + 32'(4*i));
      end
    end
    for (int k = 0; k < WORDS; k++) begin
      w = (s + k) % WORDS;
      b.w = wr;
      b.a = base + 32'(4*w);
      b.d = wr ? wdat[32*w +: 32] : 32'd0;
      bq.push_back(b);
    end
    rq.push_back(r);
    accept_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int guard = 0;
    while ((bq.size() != 0 || rq.size() != 0) && guard < 1000) begin @(negedge clk); guard++; end
    if (guard >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: beats left %0d resps left %0d", nm, bq.size(), rq.size());
      bq.delete(); rq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB-1:0] line;
    logic [31:0] old2, old3;
    int guard;
    reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    Valid = 1; resp_ready = 1; rd = 0;
    #2;
    chk("rst_req_ready", LB'(req_ready), LB'(1));
    chk("rst_outs", LB'({resp_valid, HSEL, re, we}), LB'(0));
    chk("rst_a_wd", LB'({a, wd}), LB'(0));
    chk("rst_rdata", resp_rdata, LB'(0));
    for (int i = 0; i < WORDS; i++) begin
      mem[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);
      ref_mem[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);
    end
    @(negedge clk); @(negedge clk);
    reset = 0;

    // Critical-word-first fill, no stalls.
    send(0, 32'h104, '0, WORDS + 1);
    wait_idle("fill104");

    // Writeback then a fill of the same line.
    send(1, 32'h20, {32'h44, 32'h33, 32'h22, 32'h11}, WORDS + 1);
    send(0, 32'h2C, '0, WORDS + 1);
    wait_idle("wr20");

    // Two stall cycles on the second read beat.
    vmode = 2;
    send(0, 32'h104, '0, WORDS + 3);
    wait_idle("stall");
    vmode = 0;

    // Response held off while requests are pulsed.
    rmode = 2;
    send(0, 32'h10C, '0, -1);
    guard = 0;
    while (!resp_valid && guard < 100) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0); req_write = 0; req_addr = 32'h400;
      #2;
      chk("hold_req_ready", LB'(req_ready), LB'(0));
      chk("hold_resp_valid", LB'(resp_valid), LB'(1));
      @(negedge clk);
    end
    req_valid = 0;
    rmode = 0;
    wait_idle("hold");
    send(0, 32'h400, '0, WORDS + 1);
    wait_idle("after_hold");

    // Reset in the third write beat: words 0 and 1 stay committed.
    old2 = ref_rd(32'h308);
    old3 = ref_rd(32'h30C);
    line = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    send(1, 32'h300, line, -1);
    guard = 0;
    while ((cyc - accept_cyc) != 3 && guard < 20) begin @(negedge clk); guard++; end
    #3 reset = 1;
    #1;
    chk("rstmid_outs", LB'({resp_valid, HSEL, re, we}), LB'(0));
    chk("rstmid_a_wd", LB'({a, wd}), LB'(0));
    chk("rstmid_rdata", resp_rdata, LB'(0));
    chk("rstmid_req_ready", LB'(req_ready), LB'(1));
    bq.delete(); rq.delete(); rfirst = 0;
    ref_mem[32'h308] = old2;
    ref_mem[32'h30C] = old3;
    @(negedge clk);
    #3 reset = 0;
    chk("rstmid_mem0", LB'(memrd(32'h300)), LB'(32'hA0A0A0A0));
    chk("rstmid_mem1", LB'(memrd(32'h304)), LB'(32'hB1B1B1B1));
    chk("rstmid_mem2", LB'(memrd(32'h308)), LB'(old2));
    chk("rstmid_mem3", LB'(memrd(32'h30C)), LB'(old3));
    send(0, 32'h300, '0, WORDS + 1);
    wait_idle("after_rst");

    // Line at the very top of the address space.
    send(0, 32'hFFFFFFF8, '0, WORDS + 1);
    wait_idle("top");

    // Randomized traffic with random stalls and back-pressure.
    vmode = 1; rmode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ad;
      if ($urandom_range(0, 3) == 0) ad = 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3));
      else ad = 32'h1000 + 32'(4 * $urandom_range(0, 31));
      send(1'($urandom_range(0, 1)), ad, {$urandom, $urandom, $urandom, $urandom}, -1);
    end
    wait_idle("random");
    vmode = 0; rmode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
